modulo_controlador_estoque_rolhas: RTL and testbench

MODULO_CONTROLADOR_ESTOQUE_ROLHAS -- requirements
Module: modulo_controlador_estoque_rolhas

---
 rtl/modulo_controlador_estoque_rolhas.sv | 130 +++++++++++++
 tb/tb_modulo_controlador_estoque_rolhas.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/modulo_controlador_estoque_rolhas.sv
// Stopper reservoir controller: tracks stock, grants/refuses requests, runs refill batches.
// Latency: one cycle from input edge to registered outputs; no backpressure, excess entradas are dropped.
module modulo_controlador_estoque_rolhas #(
   parameter int LARGURA        = 7,
   parameter int CAPACIDADE     = 100,
   parameter int LIMIAR_BAIXO   = 10,
   parameter int LOTE_REPOSICAO = 20,
   parameter int MODO_AUTO      = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pedido_rolha,
   input  logic               entrada_rolha,
   input  logic               req_repor,
   input  logic               cancelar_repor,
   output logic [LARGURA-1:0] qtd_rolhas,
   output logic               concede_rolha,
   output logic               falta_rolha,
   output logic               aus_rolhas,
   output logic               estoque_baixo,
   output logic               repondo,
   output logic               repos_concluida
);

   typedef enum logic {OCIOSO, REPONDO} estado_t;

   localparam logic [LARGURA-1:0] CAP       = LARGURA'(CAPACIDADE);
   localparam logic [LARGURA-1:0] LIM       = LARGURA'(LIMIAR_BAIXO);
   localparam logic [LARGURA-1:0] LIM_ACIMA = LARGURA'(LIMIAR_BAIXO + 1);
   localparam logic [LARGURA-1:0] LOTE      = LARGURA'(LOTE_REPOSICAO);
   localparam logic [LARGURA-1:0] UM        = LARGURA'(1);
   localparam logic [LARGURA-1:0] ZERO      = '0;

   estado_t            estado, estado_prox;
   logic [LARGURA-1:0] qtd, qtd_prox;
   logic [LARGURA-1:0] restante, restante_prox;
   logic               concede, concede_prox;
   logic               falta, falta_prox;
   logic               concluida, concluida_prox;
   logic               cruzou, cruzou_prox;

   logic               concede_ok;
   logic               aceita;
   logic [LARGURA-1:0] espaco;
   logic [LARGURA-1:0] carga;
   logic               disparo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= OCIOSO;
         qtd       <= ZERO;
         restante  <= ZERO;
         concede   <= 1'b0;
         falta     <= 1'b0;
         concluida <= 1'b0;
         cruzou    <= 1'b0;
      end else begin
         estado    <= estado_prox;
         qtd       <= qtd_prox;
         restante  <= restante_prox;
         concede   <= concede_prox;
         falta     <= falta_prox;
         concluida <= concluida_prox;
         cruzou    <= cruzou_prox;
      end
   end

   always_comb begin
      estado_prox    = estado;
      qtd_prox       = qtd;
      restante_prox  = restante;
      concede_prox   = 1'b0;
      falta_prox     = 1'b0;
      concluida_prox = 1'b0;

      concede_ok = pedido_rolha && (qtd != ZERO);
      aceita     = (estado == REPONDO) && entrada_rolha && (qtd < CAP);
      espaco     = CAP - qtd;
      carga      = (LOTE < espaco) ? LOTE : espaco;
      disparo    = (MODO_AUTO != 0) && cruzou;

      concede_prox = concede_ok;
      falta_prox   = pedido_rolha && (qtd == ZERO);

      // A simultaneous grant and accepted delivery cancel out on the count
      case ({aceita, concede_ok})
         2'b10:   qtd_prox = qtd + UM;
         2'b01:   qtd_prox = qtd - UM;
         default: qtd_prox = qtd;
      endcase

      case (estado)
         OCIOSO: begin
            if ((req_repor || disparo) && (qtd < CAP)) begin
               estado_prox   = REPONDO;
               restante_prox = carga;
            end
         end
         REPONDO: begin
            if (cancelar_repor) begin
               estado_prox   = OCIOSO;
               restante_prox = ZERO;
            end else if (aceita) begin
               restante_prox = restante - UM;
               if ((restante == UM) || (qtd_prox == CAP)) begin
                  estado_prox    = OCIOSO;
                  restante_prox  = ZERO;
                  concluida_prox = 1'b1;
               end
            end
         end
         default: begin
            estado_prox   = OCIOSO;
            restante_prox = ZERO;
         end
      endcase

      // Only the downward step into the low band arms the automatic refill
      cruzou_prox = (qtd == LIM_ACIMA) && (qtd_prox == LIM);
   end

   assign qtd_rolhas      = qtd;
   assign concede_rolha   = concede;
   assign falta_rolha     = falta;
   assign repos_concluida = concluida;
   assign aus_rolhas      = (qtd == ZERO);
   assign estoque_baixo   = (qtd <= LIM);
   assign repondo         = (estado == REPONDO);

endmodule

// File: tb/tb_modulo_controlador_estoque_rolhas.sv
// Bench for the stopper reservoir controller: default instance plus an automatic-refill instance.
module tb_modulo_controlador_estoque_rolhas;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pedido, entrada, req, cancelar;
   logic [6:0] qtd;
   logic       concede, falta, aus, baixo, rep, concl;
   logic       a_pedido, a_entrada, a_req, a_cancelar;
   logic [6:0] a_qtd;
   logic       a_concede, a_falta, a_aus, a_baixo, a_rep, a_concl;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [6:0] qtd;
      logic       concl;
      logic       rep;
   } esperado_t;
   esperado_t sb[$];

   always #5 clk = ~clk;

   modulo_controlador_estoque_rolhas dut (
      .clk(clk), .rst_n(rst_n), .pedido_rolha(pedido), .entrada_rolha(entrada),
      .req_repor(req), .cancelar_repor(cancelar), .qtd_rolhas(qtd),
      .concede_rolha(concede), .falta_rolha(falta), .aus_rolhas(aus),
      .estoque_baixo(baixo), .repondo(rep), .repos_concluida(concl)
   );

   modulo_controlador_estoque_rolhas #(.MODO_AUTO(1)) dut_auto (
      .clk(clk), .rst_n(rst_n), .pedido_rolha(a_pedido), .entrada_rolha(a_entrada),
      .req_repor(a_req), .cancelar_repor(a_cancelar), .qtd_rolhas(a_qtd),
      .concede_rolha(a_concede), .falta_rolha(a_falta), .aus_rolhas(a_aus),
      .estoque_baixo(a_baixo), .repondo(a_rep), .repos_concluida(a_concl)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_checks++; if (qtd !== 7'd0) begin n_fail++; $display("FAIL reset_qtd: got %0d expected 0", qtd); end
      n_checks++; if ({aus, baixo, rep} !== 3'b110) begin n_fail++; $display("FAIL reset_flags: got aus/baixo/rep=%b expected 110", {aus, baixo, rep}); end
      n_checks++; if ({concede, falta, concl} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {concede, falta, concl}); end
   endtask

   task automatic test_falta();
      pedido = 1'b1; tick(); pedido = 1'b0;
      n_checks++; if ({falta, concede} !== 2'b10) begin n_fail++; $display("FAIL falta_pulse: got falta/concede=%b expected 10", {falta, concede}); end
      n_checks++; if (qtd !== 7'd0 || aus !== 1'b1) begin n_fail++; $display("FAIL falta_qtd: got qtd=%0d aus=%b expected 0/1", qtd, aus); end
      tick();
      n_checks++; if (falta !== 1'b0) begin n_fail++; $display("FAIL falta_one_cycle: got %b expected 0", falta); end
   endtask

   task automatic test_refill();
      int pulsos = 0;
      esperado_t e;
      req = 1'b1; tick(); req = 1'b0;
      n_checks++; if (rep !== 1'b1) begin n_fail++; $display("FAIL refill_start: got repondo=%b expected 1", rep); end
      entrada = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         sb.push_back('{qtd: (i < 20) ? 7'(i) : 7'd20, concl: (i == 20), rep: (i < 20)});
         tick();
         e = sb.pop_front();
         if (concl) pulsos++;
         n_checks++; if (qtd !== e.qtd) begin n_fail++; $display("FAIL refill_qtd[%0d]: got %0d expected %0d", i, qtd, e.qtd); end
         n_checks++; if (concl !== e.concl || rep !== e.rep) begin n_fail++; $display("FAIL refill_fsm[%0d]: got concl/rep=%b%b expected %b%b", i, concl, rep, e.concl, e.rep); end
      end
      entrada = 1'b0;
      n_checks++; if (pulsos != 1) begin n_fail++; $display("FAIL refill_pulses: got %0d expected 1", pulsos); end
   endtask

   task automatic test_back_to_back();
      esperado_t e;
      req = 1'b1; tick(); req = 1'b0;
      pedido = 1'b1; entrada = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (concede !== 1'b1 || qtd !== 7'd20 || rep !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d]: got concede=%b qtd=%0d rep=%b expected 1/20/1", i, concede, qtd, rep); end
      end
      pedido = 1'b0;
      // Sixteen deliveries remain in the batch after the four overlapped ones
      for (int i = 1; i <= 16; i++) begin
         sb.push_back('{qtd: 7'(20 + i), concl: (i == 16), rep: (i < 16)});
         tick();
         e = sb.pop_front();
         n_checks++; if (qtd !== e.qtd || concl !== e.concl || rep !== e.rep) begin n_fail++; $display("FAIL b2b_rest[%0d]: got qtd=%0d concl=%b rep=%b expected %0d/%b/%b", i, qtd, concl, rep, e.qtd, e.concl, e.rep); end
      end
      entrada = 1'b0;
   endtask

   task automatic test_cancel_and_capacity();
      esperado_t e;
      for (int b = 0; b < 2; b++) begin
         req = 1'b1; tick(); req = 1'b0;
         entrada = 1'b1;
         for (int i = 0; i < 20; i++) tick();
         entrada = 1'b0;
      end
      n_checks++; if (qtd !== 7'd76 || rep !== 1'b0) begin n_fail++; $display("FAIL batches: got qtd=%0d rep=%b expected 76/0", qtd, rep); end
      req = 1'b1; tick(); req = 1'b0;
      entrada = 1'b1;
      for (int i = 0; i < 18; i++) tick();
      cancelar = 1'b1; tick(); cancelar = 1'b0; entrada = 1'b0;
      n_checks++; if (qtd !== 7'd95 || rep !== 1'b0 || concl !== 1'b0) begin n_fail++; $display("FAIL cancel: got qtd=%0d rep=%b concl=%b expected 95/0/0", qtd, rep, concl); end
      req = 1'b1; tick(); req = 1'b0;
      entrada = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         sb.push_back('{qtd: (i < 5) ? 7'(95 + i) : 7'd100, concl: (i == 5), rep: (i < 5)});
         tick();
         e = sb.pop_front();
         n_checks++; if (qtd !== e.qtd || concl !== e.concl || rep !== e.rep) begin n_fail++; $display("FAIL cap[%0d]: got qtd=%0d concl=%b rep=%b expected %0d/%b/%b", i, qtd, concl, rep, e.qtd, e.concl, e.rep); end
      end
      entrada = 1'b0;
      req = 1'b1; tick(); req = 1'b0;
      n_checks++; if (rep !== 1'b0 || qtd !== 7'd100) begin n_fail++; $display("FAIL req_at_cap: got rep=%b qtd=%0d expected 0/100", rep, qtd); end
   endtask

   task automatic test_reset_mid_refill();
      pedido = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      pedido = 1'b0;
      n_checks++; if (qtd !== 7'd97) begin n_fail++; $display("FAIL drain: got %0d expected 97", qtd); end
      req = 1'b1; tick(); req = 1'b0;
      entrada = 1'b1; tick();
      n_checks++; if (qtd !== 7'd98 || rep !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got qtd=%0d rep=%b expected 98/1", qtd, rep); end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_checks++; if (qtd !== 7'd0 || {aus, baixo, rep} !== 3'b110 || {concede, falta, concl} !== 3'b000) begin n_fail++; $display("FAIL async_reset: got qtd=%0d flags=%b pulses=%b expected 0/110/000", qtd, {aus, baixo, rep}, {concede, falta, concl}); end
      entrada = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      n_checks++; if (rep !== 1'b0 || concl !== 1'b0 || qtd !== 7'd0) begin n_fail++; $display("FAIL post_reset: got rep=%b concl=%b qtd=%0d expected 0/0/0", rep, concl, qtd); end
   endtask

   task automatic test_auto_refill();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (a_rep !== 1'b0) begin n_fail++; $display("FAIL auto_after_reset[%0d]: got rep=%b expected 0", i, a_rep); end
      end
      a_req = 1'b1; tick(); a_req = 1'b0;
      a_entrada = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      a_entrada = 1'b0;
      a_pedido = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      a_pedido = 1'b0;
      n_checks++; if (a_qtd !== 7'd11 || a_rep !== 1'b0) begin n_fail++; $display("FAIL auto_prep: got qtd=%0d rep=%b expected 11/0", a_qtd, a_rep); end
      a_pedido = 1'b1; tick(); a_pedido = 1'b0;
      n_checks++; if (a_qtd !== 7'd10 || a_baixo !== 1'b1 || a_concede !== 1'b1) begin n_fail++; $display("FAIL auto_cross: got qtd=%0d baixo=%b concede=%b expected 10/1/1", a_qtd, a_baixo, a_concede); end
      tick();
      n_checks++; if (a_rep !== 1'b1) begin n_fail++; $display("FAIL auto_trigger: got rep=%b expected 1", a_rep); end
      a_cancelar = 1'b1; tick(); a_cancelar = 1'b0;
      n_checks++; if (a_rep !== 1'b0 || a_concl !== 1'b0) begin n_fail++; $display("FAIL auto_cancel: got rep=%b concl=%b expected 0/0", a_rep, a_concl); end
      a_pedido = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (a_rep !== 1'b0) begin n_fail++; $display("FAIL auto_no_retrigger[%0d]: got rep=%b expected 0", i, a_rep); end
      end
      a_pedido = 1'b0;
      tick();
      n_checks++; if (a_rep !== 1'b0 || a_qtd !== 7'd6) begin n_fail++; $display("FAIL auto_final: got rep=%b qtd=%0d expected 0/6", a_rep, a_qtd); end
   endtask

   initial begin
      rst_n = 1'b0;
      {pedido, entrada, req, cancelar} = '0;
      {a_pedido, a_entrada, a_req, a_cancelar} = '0;
      #12;
      test_reset();
      rst_n = 1'b1;
      test_falta();
      test_refill();
      test_back_to_back();
      test_cancel_and_capacity();
      test_reset_mid_refill();
      test_auto_refill();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
